// File: rtl/mc14500_sequencer.sv
// Fetch/execute sequencer for the MC14500 one-bit system: program counter, return stack,
// skip/jump/return control, operand routing to the input mux or output-latch readback.
module mc14500_sequencer #(
    parameter int ADDR_W      = 7,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [3:0]        lu_instruction,
    output logic              lu_strobe,
    output logic              lu_data_in,
    input  logic              lu_data_out,
    input  logic              lu_write_mode,
    input  logic              lu_result,
    output logic [2:0]        imux_abc,
    output logic              imux_inh,
    input  logic              imux_z,
    input  logic [7:0]        olat_q,
    output logic [2:0]        olat_addr,
    output logic              olat_data,
    output logic              olat_we,
    output logic              flg0,
    output logic              flgf,
    output logic [ADDR_W-1:0] pc,
    output logic              stack_err,
    output logic              busy
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, JTGT} state_t;

    state_t            state, state_nx;
    logic [7:0]        ir;
    logic [3:0]        op;
    logic [SP_W-1:0]   sp, sp_nx;
    logic [ADDR_W-1:0] pc_nx, rom_addr_nx;
    logic              err_nx, push, exec;
    logic [ADDR_W-1:0] stack [0:(1<<IDX_W)-1];

    assign op   = ir[7:4];
    // Strobes are gated by reset so an aborted instruction never writes.
    assign exec = (state == EXEC) && reset;

    assign lu_strobe      = exec;
    assign lu_instruction = ir[7:4];
    assign imux_abc       = ir[2:0];
    assign imux_inh       = !(exec && !ir[3]);
    assign lu_data_in     = ir[3] ? olat_q[ir[2:0]] : imux_z;
    assign olat_addr      = ir[2:0];
    assign olat_data      = lu_data_out;
    assign olat_we        = exec && ir[3] && (op == 4'h8 || op == 4'h9) && lu_write_mode;
    assign flg0           = exec && (op == 4'h0);
    assign flgf           = exec && (op == 4'hF);
    assign busy           = (state != IDLE);

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        rom_addr_nx = rom_addr;
        sp_nx       = sp;
        err_nx      = stack_err;
        push        = 1'b0;
        case (state)
            IDLE:  if (run) state_nx = FETCH;
            FETCH: state_nx = EXEC;
            EXEC: begin
                pc_nx = pc + ADDR_W'(1);
                case (op)
                    4'hE: if (!lu_result) pc_nx = pc + ADDR_W'(2);
                    4'hC: pc_nx = pc;
                    4'hD: begin
                        if (sp == '0) begin
                            err_nx = 1'b1;
                        end else begin
                            pc_nx = stack[IDX_W'(sp - 1'b1)];
                            sp_nx = sp - 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (op == 4'hC) begin
                    // Jump target sits in the following ROM word.
                    state_nx    = JTGT;
                    rom_addr_nx = pc + ADDR_W'(1);
                end else begin
                    state_nx    = run ? FETCH : IDLE;
                    rom_addr_nx = pc_nx;
                end
            end
            JTGT: begin
                pc_nx       = rom_data[ADDR_W-1:0];
                rom_addr_nx = rom_data[ADDR_W-1:0];
                state_nx    = run ? FETCH : IDLE;
                if (sp == SP_W'(STACK_DEPTH)) begin
                    err_nx = 1'b1;
                end else begin
                    push  = 1'b1;
                    sp_nx = sp + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= '0;
            rom_addr  <= '0;
            sp        <= '0;
            stack_err <= 1'b0;
            ir        <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            rom_addr  <= rom_addr_nx;
            sp        <= sp_nx;
            stack_err <= err_nx;
            if (state == FETCH) ir <= rom_data;
        end
    end

    // Return addresses are pure data and need no reset.
    always_ff @(posedge clk) begin
        if (reset && push) stack[IDX_W'(sp)] <= pc + ADDR_W'(2);
    end

endmodule

// File: tb/tb_mc14500_sequencer.sv
// Bench for mc14500_sequencer: random program executed by an instruction-level model,
// scoreboarded per EXEC cycle, followed by directed reset/jump/stop sequences.
module tb_mc14500_sequencer;

    localparam int AW = 7;
    localparam int DEPTH = 4;
    localparam int NINSTR = 400;
    localparam int SLACK = 50;

    logic clk = 1'b0;
    logic reset, run;
    logic [AW-1:0] rom_addr, pc;
    logic [7:0] rom_data, olat_q;
    logic [3:0] lu_instruction;
    logic lu_strobe, lu_data_in, lu_data_out, lu_write_mode, lu_result;
    logic [2:0] imux_abc, olat_addr;
    logic imux_inh, imux_z, olat_data, olat_we, flg0, flgf, stack_err, busy;

    logic [7:0] rom [128];
    logic       res_tab [128];
    logic       z_tab [128];
    logic       wm_tab [128];
    logic       dout_tab [128];
    logic [7:0] q_tab [128];

    assign rom_data      = rom[rom_addr];
    assign lu_result     = res_tab[rom_addr];
    assign imux_z        = z_tab[rom_addr];
    assign lu_write_mode = wm_tab[rom_addr];
    assign lu_data_out   = dout_tab[rom_addr];
    assign olat_q        = q_tab[rom_addr];

    mc14500_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
        .lu_instruction(lu_instruction), .lu_strobe(lu_strobe), .lu_data_in(lu_data_in),
        .lu_data_out(lu_data_out), .lu_write_mode(lu_write_mode), .lu_result(lu_result),
        .imux_abc(imux_abc), .imux_inh(imux_inh), .imux_z(imux_z), .olat_q(olat_q),
        .olat_addr(olat_addr), .olat_data(olat_data), .olat_we(olat_we), .flg0(flg0),
        .flgf(flgf), .pc(pc), .stack_err(stack_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] pc;
        logic [3:0] op;
        logic [2:0] abc;
        logic       inh, din, we, odata, f0, ff, err;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction-level interpreter of the program in rom[]/env tables.
    task automatic build_model();
        int p = 0;
        int stk[$];
        logic err = 1'b0;
        logic [7:0] w;
        exp_t e;
        for (int i = 0; i < NINSTR + SLACK; i++) begin
            w = rom[p];
            e.pc = 7'(p);
            e.op = w[7:4];
            e.abc = w[2:0];
            e.inh = w[3];
            e.din = w[3] ? q_tab[p][w[2:0]] : z_tab[p];
            e.we = w[3] && (w[7:4] == 4'h8 || w[7:4] == 4'h9) && wm_tab[p];
            e.odata = dout_tab[p];
            e.f0 = (w[7:4] == 4'h0);
            e.ff = (w[7:4] == 4'hF);
            e.err = err;
            expq.push_back(e);
            case (w[7:4])
                4'hE: p = (p + (res_tab[p] ? 1 : 2)) % 128;
                4'hC: begin
                    if (stk.size() == DEPTH) err = 1'b1;
                    else stk.push_back((p + 2) % 128);
                    p = rom[(p + 1) % 128] % 128;
                end
                4'hD: begin
                    if (stk.size() == 0) begin
                        err = 1'b1;
                        p = (p + 1) % 128;
                    end else begin
                        p = stk.pop_back();
                    end
                end
                default: p = (p + 1) % 128;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (lu_strobe) begin
                if (expq.size() == 0) begin
                    chk("extra_exec", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("exec_pc", pc, e.pc);
                    chk("exec_opcode", lu_instruction, e.op);
                    chk("route", {imux_abc, imux_inh, lu_data_in}, {e.abc, e.inh, e.din});
                    chk("latch", {olat_we, olat_addr, olat_data}, {e.we, e.abc, e.odata});
                    chk("flags_err", {flg0, flgf, stack_err}, {e.f0, e.ff, e.err});
                end
            end else begin
                chk("idle_strobes", {olat_we, flg0, flgf, imux_inh}, 4'b0001);
            end
        end
    end

    initial begin
        reset = 1'b0;
        run = 1'b0;
        for (int a = 0; a < 128; a++) begin
            rom[a] = 8'($urandom);
            res_tab[a] = 1'($urandom);
            z_tab[a] = 1'($urandom);
            wm_tab[a] = 1'($urandom);
            dout_tab[a] = 1'($urandom);
            q_tab[a] = 8'($urandom);
        end
        build_model();
        tick();
        tick();
        reset = 1'b1;
        mon_en = 1'b1;
        for (int c = 0; c < 20000 && expq.size() > SLACK; c++) begin
            run = ($urandom_range(0, 9) != 0);
            tick();
        end
        chk("random_drain", expq.size() > SLACK, 1'b0);
        mon_en = 1'b0;

        // Directed: reset state, JMP timing, abort during JTGT.
        for (int a = 0; a < 128; a++) begin
            rom[a] = 8'h13;
            res_tab[a] = 1'b0; z_tab[a] = 1'b0; wm_tab[a] = 1'b0;
            dout_tab[a] = 1'b0; q_tab[a] = 8'h00;
        end
        rom[0] = 8'hC8; rom[1] = 8'h10; rom[8'h10] = 8'hC0; rom[8'h11] = 8'h20;
        reset = 1'b0;
        run = 1'b1;
        tick();
        chk("rst_pc_addr", {pc, rom_addr}, 14'd0);
        chk("rst_ctrl", {busy, stack_err, lu_strobe, olat_we, flg0, flgf}, 6'd0);
        chk("rst_outs", {imux_inh, lu_instruction}, 5'b10000);
        reset = 1'b1;
        tick();
        chk("fetch0", {busy, rom_addr}, {1'b1, 7'h00});
        tick();
        chk("jmp_exec", {lu_strobe, lu_instruction, pc}, {1'b1, 4'hC, 7'h00});
        tick();
        chk("jmp_jtgt", {lu_strobe, rom_addr}, {1'b0, 7'h01});
        tick();
        chk("jmp_fetch", {pc, rom_addr}, {7'h10, 7'h10});
        tick();
        chk("jmp2_exec", {lu_strobe, pc}, {1'b1, 7'h10});
        tick();
        chk("jmp2_jtgt", rom_addr, 7'h11);
        reset = 1'b0;
        #1;
        chk("abort_strobes", {olat_we, lu_strobe}, 2'b00);
        tick();
        chk("abort_state", {busy, pc, rom_addr, stack_err}, 16'd0);

        // RTN on a freshly reset stack, then stop with run=0.
        rom[0] = 8'hD0; rom[1] = 8'h00; rom[2] = 8'h88; wm_tab[2] = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        chk("rtn_exec", lu_instruction, 4'hD);
        tick();
        chk("rtn_empty", {pc, stack_err}, {7'h01, 1'b1});
        run = 1'b0;
        tick();
        chk("nop0_flag", {lu_strobe, flg0, flgf}, 3'b110);
        tick();
        chk("stopped", {busy, pc, flg0}, {1'b0, 7'h02, 1'b0});
        tick(); tick(); tick();
        chk("held", {busy, pc}, {1'b0, 7'h02});

        // Store strobe, then reset in the same EXEC cycle suppresses it.
        run = 1'b1;
        tick();
        tick();
        chk("sto_we", {olat_we, olat_addr}, {1'b1, 3'd0});
        reset = 1'b0;
        #1;
        chk("sto_abort", olat_we, 1'b0);
        tick();
        chk("sto_abort_state", {busy, pc}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
